// File: rtl/zero_strip.sv
// zero_strip: streaming packet truncator. Forwards only the first keep_len
// words of each AXI-stream packet, discards the tail, and re-generates tlast
// on the last kept word. keep_len == 0 passes packets through untouched.
module zero_strip #(
  parameter int WIDTH = 32,
  parameter int LEN_W = 16
) (
  input  logic             ce_clk,
  input  logic             reset_n,
  input  logic [LEN_W-1:0] keep_len,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] o_tdata,
  output logic             o_tlast,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             short_pkt,
  output logic [31:0]      drop_cnt
);

  localparam logic [0:0] PASS = 1'b0;
  localparam logic [0:0] DROP = 1'b1;

  localparam logic [LEN_W-1:0] CNT_MAX = '1;
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  logic [0:0]       state;
  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] klen;
  logic [LEN_W-1:0] eff_klen;
  logic             accept;
  logic             last_kept;
  logic             ends_short;

  // Ready never looks at i_tvalid: DROP always sinks, PASS sinks when the
  // output register is empty or being emptied this cycle.
  assign i_tready = (state == DROP) | ~o_tvalid | o_tready;
  assign accept   = i_tvalid & i_tready;

  // The first word of a packet must compare against keep_len directly because
  // klen is only loaded by that same word.
  always_comb begin
    eff_klen   = (cnt == '0) ? keep_len : klen;
    last_kept  = (eff_klen != '0) && (cnt == eff_klen - ONE);
    ends_short = i_tlast && (eff_klen != '0) && (cnt < eff_klen - ONE);
  end

  // Word index within the input packet and the per-packet length latch;
  // the index saturates so very long pass-through packets never wrap it.
  always_ff @(posedge ce_clk) begin
    if (!reset_n) begin
      cnt  <= '0;
      klen <= '0;
    end else if (accept) begin
      if (cnt == '0)
        klen <= keep_len;
      if (i_tlast)
        cnt <= '0;
      else if (cnt != CNT_MAX)
        cnt <= cnt + ONE;
    end
  end

  // PASS/DROP sequencing: enter DROP after the last kept word of a packet
  // that continues, leave it when the packet's own tlast is consumed.
  always_ff @(posedge ce_clk) begin
    if (!reset_n) begin
      state <= PASS;
    end else if (accept) begin
      if (state == PASS) begin
        if (last_kept && !i_tlast)
          state <= DROP;
      end else if (i_tlast) begin
        state <= PASS;
      end
    end
  end

  // Output register: loaded only by words accepted in PASS, otherwise
  // drains independently of the input side.
  always_ff @(posedge ce_clk) begin
    if (!reset_n) begin
      o_tdata  <= '0;
      o_tlast  <= 1'b0;
      o_tvalid <= 1'b0;
    end else if (accept && state == PASS) begin
      o_tdata  <= i_tdata;
      o_tlast  <= i_tlast | last_kept;
      o_tvalid <= 1'b1;
    end else if (o_tready) begin
      o_tvalid <= 1'b0;
    end
  end

  // Status: one-cycle short-packet pulse and running count of discarded words.
  always_ff @(posedge ce_clk) begin
    if (!reset_n) begin
      short_pkt <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      short_pkt <= accept && (state == PASS) && ends_short;
      if (accept && state == DROP)
        drop_cnt <= drop_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_zero_strip.sv
// tb_zero_strip: randomized self-checking bench for zero_strip. A packet-level
// model predicts the kept words, drop total and short-packet count.
module tb_zero_strip;

  localparam int WIDTH = 32;
  localparam int LEN_W = 16;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  logic             ce_clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [LEN_W-1:0] keep_len = '0;
  logic [WIDTH-1:0] i_tdata = '0;
  logic             i_tlast = 1'b0;
  logic             i_tvalid = 1'b0;
  logic             i_tready;
  logic [WIDTH-1:0] o_tdata;
  logic             o_tlast;
  logic             o_tvalid;
  logic             o_tready = 1'b0;
  logic             short_pkt;
  logic [31:0]      drop_cnt;

  int compared = 0;
  int mismatched = 0;

  beat_t            exp_q[$];
  beat_t            got_q[$];
  logic [WIDTH-1:0] sent[$];
  logic [31:0]      exp_drops = '0;
  int               exp_short = 0;
  int               short_seen = 0;
  int               stall_err = 0;
  int               bubbles = 0;
  int               rdy_prob = 100;
  logic             prev_stall = 1'b0;
  beat_t            prev_beat;

  zero_strip #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
    .ce_clk(ce_clk), .reset_n(reset_n), .keep_len(keep_len),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .short_pkt(short_pkt), .drop_cnt(drop_cnt)
  );

  // Free-running clock.
  always #5 ce_clk = ~ce_clk;

  // Downstream ready, randomized with the current acceptance probability.
  always @(negedge ce_clk) o_tready = ($urandom_range(99) < rdy_prob);

  // Output monitor sampled just before the rising edge: records transfers,
  // short pulses and any change of a stalled output beat.
  always @(negedge ce_clk) begin
    #2;
    if (reset_n) begin
      if (short_pkt) short_seen++;
      if (prev_stall && (o_tvalid !== 1'b1 || o_tdata !== prev_beat.data || o_tlast !== prev_beat.last))
        stall_err++;
      if (o_tvalid && o_tready) got_q.push_back({o_tdata, o_tlast});
      prev_stall = o_tvalid && !o_tready;
      prev_beat  = {o_tdata, o_tlast};
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Drive one packet of len words (stopping after nwords) and, if asked,
  // append the model's prediction for it.
  task automatic send_pkt(input int len, input int nwords, input int kl, input int chg_at,
                          input int kl2, input int vprob, input bit model);
    logic [WIDTH-1:0] d;
    int waited;
    bit done;
    int nout;
    sent.delete();
    for (int w = 0; w < nwords; w++) begin
      d = $urandom;
      waited = 0;
      done = 1'b0;
      while (!done) begin
        @(negedge ce_clk);
        i_tvalid = ($urandom_range(99) < vprob);
        i_tdata  = d;
        i_tlast  = (w == len - 1);
        keep_len = LEN_W'((w >= chg_at) ? kl2 : kl);
        #1;
        if (i_tvalid && !i_tready) bubbles++;
        if (i_tvalid && i_tready) begin
          done = 1'b1;
        end else if (++waited > 1000) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL accept_timeout: word %0d ready=%b, required 1", w, i_tready);
          done = 1'b1;
        end
      end
      @(posedge ce_clk);
      sent.push_back(d);
    end
    if (model) begin
      nout = (kl == 0 || len <= kl) ? len : kl;
      for (int i = 0; i < nout; i++) exp_q.push_back({sent[i], (i == nout - 1)});
      exp_drops += 32'(len - nout);
      if (kl != 0 && len < kl) exp_short++;
    end
  endtask

  // Idle the input and let the output drain fully.
  task automatic drain();
    int waited = 0;
    @(negedge ce_clk);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    rdy_prob = 100;
    while (got_q.size() < exp_q.size() && waited < 2000) begin
      @(negedge ce_clk);
      waited++;
    end
    repeat (5) @(negedge ce_clk);
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    rdy_prob = 100;
    repeat (3) @(negedge ce_clk);
    #3;
    compared += 6;
    if (o_tvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_o_tvalid: got %b, required 0", o_tvalid); end
    if (o_tdata !== '0) begin mismatched++; $display("[TB] FAIL reset_o_tdata: got %h, required 0", o_tdata); end
    if (o_tlast !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_o_tlast: got %b, required 0", o_tlast); end
    if (short_pkt !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_short_pkt: got %b, required 0", short_pkt); end
    if (drop_cnt !== 32'd0) begin mismatched++; $display("[TB] FAIL reset_drop_cnt: got %0d, required 0", drop_cnt); end
    if (i_tready !== 1'b1) begin mismatched++; $display("[TB] FAIL reset_i_tready: got %b, required 1", i_tready); end
    @(negedge ce_clk);
    reset_n = 1'b1;
  endtask

  task automatic test_truncate();
    bubbles = 0;
    send_pkt(32, 32, 20, 1000, 0, 100, 1'b1);
    send_pkt(32, 32, 20, 1000, 0, 100, 1'b1);
    drain();
    compared++;
    if (got_q.size() !== exp_q.size()) begin mismatched++; $display("[TB] FAIL truncate_count: got %0d beats, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      compared++;
      if (got_q[i] !== exp_q[i]) begin mismatched++; $display("[TB] FAIL truncate_beat%0d: got %h/%b, required %h/%b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last); end
    end
    compared += 2;
    if (drop_cnt !== exp_drops) begin mismatched++; $display("[TB] FAIL truncate_drop_cnt: got %0d, required %0d", drop_cnt, exp_drops); end
    if (bubbles !== 0) begin mismatched++; $display("[TB] FAIL truncate_bubbles: got %0d stalled cycles, required 0", bubbles); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_short();
    send_pkt(10, 10, 20, 1000, 0, 100, 1'b1);
    drain();
    compared++;
    if (got_q.size() !== exp_q.size()) begin mismatched++; $display("[TB] FAIL short_count: got %0d beats, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      compared++;
      if (got_q[i] !== exp_q[i]) begin mismatched++; $display("[TB] FAIL short_beat%0d: got %h/%b, required %h/%b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last); end
    end
    compared += 2;
    if (short_seen !== exp_short) begin mismatched++; $display("[TB] FAIL short_pulses: got %0d, required %0d", short_seen, exp_short); end
    if (drop_cnt !== exp_drops) begin mismatched++; $display("[TB] FAIL short_drop_cnt: got %0d, required %0d", drop_cnt, exp_drops); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_passthrough();
    send_pkt(32, 32, 0, 1000, 0, 100, 1'b1);
    drain();
    compared++;
    if (got_q.size() !== exp_q.size()) begin mismatched++; $display("[TB] FAIL pass_count: got %0d beats, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      compared++;
      if (got_q[i] !== exp_q[i]) begin mismatched++; $display("[TB] FAIL pass_beat%0d: got %h/%b, required %h/%b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last); end
    end
    compared++;
    if (drop_cnt !== exp_drops) begin mismatched++; $display("[TB] FAIL pass_drop_cnt: got %0d, required %0d", drop_cnt, exp_drops); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_backpressure();
    stall_err = 0;
    rdy_prob  = 50;
    for (int p = 0; p < 4; p++) send_pkt(8, 8, 4, 1000, 0, 80, 1'b1);
    drain();
    compared++;
    if (got_q.size() !== exp_q.size()) begin mismatched++; $display("[TB] FAIL bp_count: got %0d beats, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      compared++;
      if (got_q[i] !== exp_q[i]) begin mismatched++; $display("[TB] FAIL bp_beat%0d: got %h/%b, required %h/%b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last); end
    end
    compared += 2;
    if (stall_err !== 0) begin mismatched++; $display("[TB] FAIL bp_stability: got %0d unstable cycles, required 0", stall_err); end
    if (drop_cnt !== exp_drops) begin mismatched++; $display("[TB] FAIL bp_drop_cnt: got %0d, required %0d", drop_cnt, exp_drops); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    stall_err = 0;
    rdy_prob  = 60;
    for (int p = 0; p < 12; p++) begin
      int len = $urandom_range(24, 1);
      send_pkt(len, len, $urandom_range(12, 0), 1000, 0, 70, 1'b1);
    end
    drain();
    compared++;
    if (got_q.size() !== exp_q.size()) begin mismatched++; $display("[TB] FAIL rand_count: got %0d beats, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      compared++;
      if (got_q[i] !== exp_q[i]) begin mismatched++; $display("[TB] FAIL rand_beat%0d: got %h/%b, required %h/%b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last); end
    end
    compared += 3;
    if (stall_err !== 0) begin mismatched++; $display("[TB] FAIL rand_stability: got %0d unstable cycles, required 0", stall_err); end
    if (drop_cnt !== exp_drops) begin mismatched++; $display("[TB] FAIL rand_drop_cnt: got %0d, required %0d", drop_cnt, exp_drops); end
    if (short_seen !== exp_short) begin mismatched++; $display("[TB] FAIL rand_short: got %0d, required %0d", short_seen, exp_short); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_keep_change();
    send_pkt(32, 32, 20, 3, 5, 100, 1'b1);
    send_pkt(32, 32, 5, 1000, 0, 100, 1'b1);
    drain();
    compared++;
    if (got_q.size() !== exp_q.size()) begin mismatched++; $display("[TB] FAIL kchg_count: got %0d beats, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      compared++;
      if (got_q[i] !== exp_q[i]) begin mismatched++; $display("[TB] FAIL kchg_beat%0d: got %h/%b, required %h/%b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last); end
    end
    compared++;
    if (drop_cnt !== exp_drops) begin mismatched++; $display("[TB] FAIL kchg_drop_cnt: got %0d, required %0d", drop_cnt, exp_drops); end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_mid();
    rdy_prob = 100;
    send_pkt(32, 10, 20, 1000, 0, 100, 1'b0);
    for (int i = 0; i < 9; i++) exp_q.push_back({sent[i], 1'b0});
    @(negedge ce_clk);
    reset_n  = 1'b0;
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    @(posedge ce_clk);
    #1;
    compared += 2;
    if (o_tvalid !== 1'b0) begin mismatched++; $display("[TB] FAIL rmid_o_tvalid: got %b, required 0", o_tvalid); end
    if (got_q.size() !== exp_q.size()) begin mismatched++; $display("[TB] FAIL rmid_pre_count: got %0d beats, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      compared++;
      if (got_q[i] !== exp_q[i]) begin mismatched++; $display("[TB] FAIL rmid_pre_beat%0d: got %h/%b, required %h/%b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last); end
    end
    exp_q.delete(); got_q.delete();
    exp_drops = '0;
    @(negedge ce_clk);
    reset_n = 1'b1;
    send_pkt(32, 32, 20, 1000, 0, 100, 1'b1);
    drain();
    compared++;
    if (got_q.size() !== exp_q.size()) begin mismatched++; $display("[TB] FAIL rmid_count: got %0d beats, required %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      compared++;
      if (got_q[i] !== exp_q[i]) begin mismatched++; $display("[TB] FAIL rmid_beat%0d: got %h/%b, required %h/%b", i, got_q[i].data, got_q[i].last, exp_q[i].data, exp_q[i].last); end
    end
    compared++;
    if (drop_cnt !== exp_drops) begin mismatched++; $display("[TB] FAIL rmid_drop_cnt: got %0d, required %0d", drop_cnt, exp_drops); end
    exp_q.delete(); got_q.delete();
  endtask

  // Scenario sequence and summary.
  initial begin
    test_reset();
    test_truncate();
    test_short();
    test_passthrough();
    test_backpressure();
    test_random();
    test_keep_change();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Hard stop in case the run stalls somewhere unbounded.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
